// File: rtl/alu_issue_seq.sv
// alu_issue_seq: decodes an ALU request, issues it to an external
// combinational ALU and returns the result over a valid/ready response.
// One request is in flight at a time: IDLE -> EXEC -> DONE.
// Optional build macro ALU_BRANCH_EN: decodes ALUOp 01 as branch compares
// and adds the BranchTaken output. Without it, ALUOp 01 decodes to SUB.
module alu_issue_seq #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic                     Funct7b5,
  input  logic [DATA_WIDTH-1:0]    OpA,
  input  logic [DATA_WIDTH-1:0]    OpB,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result,
`ifdef ALU_BRANCH_EN
  output logic                     BranchTaken,
`endif
  output logic                     Illegal
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);
`ifdef ALU_BRANCH_EN
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic                     accept;
  logic [OPCODE_LENGTH-1:0] dec_op;
`ifdef ALU_BRANCH_EN
  logic                     dec_bne;
  logic                     bne_q;
`endif

  // Decode instruction class/function fields into an ALU operation code.
  always_comb begin
    dec_op = OP_ILL;
`ifdef ALU_BRANCH_EN
    dec_bne = 1'b0;
`endif
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
`ifdef ALU_BRANCH_EN
        case (Funct3)
          3'b000: dec_op = OP_EQ;
          3'b001: begin
            dec_op  = OP_EQ;
            dec_bne = 1'b1;
          end
          3'b100: dec_op = OP_SLT;
          default: dec_op = OP_ILL;
        endcase
`else
        dec_op = OP_SUB;
`endif
      end
      default: begin
        // R-type (10) and I-type (11); only R-type honours Funct7b5 for SUB.
        case (Funct3)
          3'b000: dec_op = (ALUOp == 2'b10 && Funct7b5) ? OP_SUB : OP_ADD;
          3'b111: dec_op = OP_AND;
          3'b110: dec_op = OP_OR;
          3'b100: dec_op = OP_XOR;
          3'b010: dec_op = OP_SLT;
          default: dec_op = OP_ILL;
        endcase
      end
    endcase
  end

  // Next state and request handshake; a DONE slot freed by out_ready may accept.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept  = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Issue registers: captured on accept, held through EXEC and DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      SrcA      <= '0;
      SrcB      <= '0;
      Operation <= OP_AND;
`ifdef ALU_BRANCH_EN
      bne_q     <= 1'b0;
`endif
    end else if (accept) begin
      SrcA      <= OpA;
      SrcB      <= OpB;
      Operation <= dec_op;
`ifdef ALU_BRANCH_EN
      bne_q     <= dec_bne;
`endif
    end
  end

  // Response registers: result captured at EXEC->DONE, held under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      Result      <= '0;
      Illegal     <= 1'b0;
`ifdef ALU_BRANCH_EN
      BranchTaken <= 1'b0;
`endif
    end else begin
      out_valid <= (state_d == DONE);
      if (state_q == EXEC) begin
        Result      <= ALUResult;
        Illegal     <= (Operation == OP_ILL);
`ifdef ALU_BRANCH_EN
        BranchTaken <= ALUResult[0] ^ bne_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: driver pushes expected responses from a
// mnemonic-level reference model; a monitor pops and compares on each response.
// Honours ALU_BRANCH_EN the same way as the design.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [2:0]  Funct3;
  logic        Funct7b5;
  logic [31:0] OpA, OpB, SrcA, SrcB, ALUResult, Result;
  logic [3:0]  Operation;
  logic        out_valid, out_ready, Illegal;
`ifdef ALU_BRANCH_EN
  logic        BranchTaken;
`endif

  alu_issue_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct3(Funct3), .Funct7b5(Funct7b5), .OpA(OpA), .OpB(OpB),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ALUResult(ALUResult),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
`ifdef ALU_BRANCH_EN
    .BranchTaken(BranchTaken),
`endif
    .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    case (Operation)
      4'b0000: ALUResult = SrcA & SrcB;
      4'b0001: ALUResult = SrcA | SrcB;
      4'b0010: ALUResult = SrcA + SrcB;
      4'b0011: ALUResult = SrcA ^ SrcB;
      4'b0110: ALUResult = SrcA - SrcB;
      4'b1000: ALUResult = (SrcA == SrcB) ? 32'd1 : 32'd0;
      4'b1100: ALUResult = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
      default: ALUResult = 32'd0;
    endcase
  end

  typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_EQ, M_ILL} mn_t;
  typedef struct {
    logic [31:0] res;
    logic [3:0]  op;
    logic        ill;
    logic        br;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  bit   seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: instruction fields -> mnemonic -> arithmetic result.
  function automatic exp_t model(input logic [1:0] aop, input logic [2:0] f3,
                                 input logic f7, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    mn_t  mn;
    if (aop == 2'b00) mn = M_ADD;
    else if (aop == 2'b01) begin
`ifdef ALU_BRANCH_EN
      if (f3 == 3'd0 || f3 == 3'd1) mn = M_EQ;
      else if (f3 == 3'd4)          mn = M_SLT;
      else                          mn = M_ILL;
`else
      mn = M_SUB;
`endif
    end else begin
      case (f3)
        3'd0: mn = (aop == 2'b10 && f7) ? M_SUB : M_ADD;
        3'd7: mn = M_AND;
        3'd6: mn = M_OR;
        3'd4: mn = M_XOR;
        3'd2: mn = M_SLT;
        default: mn = M_ILL;
      endcase
    end
    e.ill = 1'b0;
    e.acc = 0;
    case (mn)
      M_ADD: begin e.res = a + b; e.op = 4'b0010; end
      M_SUB: begin e.res = a - b; e.op = 4'b0110; end
      M_AND: begin e.res = a & b; e.op = 4'b0000; end
      M_OR:  begin e.res = a | b; e.op = 4'b0001; end
      M_XOR: begin e.res = a ^ b; e.op = 4'b0011; end
      M_SLT: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.op = 4'b1100; end
      M_EQ:  begin e.res = (a == b) ? 32'd1 : 32'd0; e.op = 4'b1000; end
      default: begin e.res = 32'd0; e.op = 4'b1111; e.ill = 1'b1; end
    endcase
    e.br = e.res[0] ^ (aop == 2'b01 && f3 == 3'd1);
    return e;
  endfunction

  function automatic logic pick_ready();
    if (rdy_mode == 0) return 1'b1;
    if (rdy_mode == 1) return 1'b0;
    return ($urandom % 4) != 0;
  endfunction

  // Offer a request until accepted; push its expected response on acceptance.
  task automatic send(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b, output int waits);
    bit   done = 0;
    exp_t e;
    waits = 0;
    while (!done) begin
      @(negedge clk);
      out_ready = pick_ready();
      in_valid = 1'b1; ALUOp = aop; Funct3 = f3; Funct7b5 = f7; OpA = a; OpB = b;
      #1;
      waits++;
      if (in_ready) begin
        e = model(aop, f3, f7, a, b);
        e.acc = cyc;
        q.push_back(e);
        done = 1;
      end else if (waits > 200) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        done = 1;
      end
    end
  endtask

  // Idle cycles with garbage on the request fields.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      out_ready = pick_ready();
      in_valid = 1'b0;
      ALUOp = 2'($urandom); Funct3 = 3'($urandom); Funct7b5 = 1'($urandom);
      OpA = $urandom; OpB = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    while (q.size() > 0 && n < 50) begin
      idle(1);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compare each presented response against the scoreboard front.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      q.delete();
      seen = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc - q[0].acc), 32'd2);
          seen = 1;
        end
        chk("result", Result, q[0].res);
        chk("illegal", 32'(Illegal), 32'(q[0].ill));
        chk("operation_done", 32'(Operation), 32'(q[0].op));
`ifdef ALU_BRANCH_EN
        chk("branch_taken", 32'(BranchTaken), 32'(q[0].br));
`endif
        if (!out_ready) chk("in_ready_bp", 32'(in_ready), 32'd0);
        else begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end else if (q.size() > 0 && cyc == q[0].acc + 1) begin
      chk("operation_exec", 32'(Operation), 32'(q[0].op));
    end
  end

  initial begin
    int w;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = '0; Funct3 = '0; Funct7b5 = 1'b0; OpA = '0; OpB = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_operation", 32'(Operation), 32'd0);
    chk("rst_srca", SrcA, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed: SUB, signed SLT, I-type ADD ignoring Funct7b5, illegal, ALUOp 01.
    rdy_mode = 0;
    send(2'b10, 3'b000, 1'b1, 32'd7, 32'd9, w);          idle(3);
    send(2'b10, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, w);  idle(3);
    send(2'b11, 3'b000, 1'b1, 32'd5, 32'd3, w);          idle(3);
    send(2'b10, 3'b001, 1'b0, 32'd11, 32'd22, w);        idle(3);
    send(2'b01, 3'b001, 1'b0, 32'd4, 32'd4, w);          idle(3);
    drain();

    // Backpressure for several cycles, then a same-cycle release and accept.
    rdy_mode = 1;
    send(2'b00, 3'b101, 1'b1, 32'h1234_0000, 32'h0000_5678, w);
    idle(7);
    rdy_mode = 0;
    send(2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, w);
    chk("same_cycle_accept", 32'(w), 32'd1);
    @(posedge clk); #1;
    chk("exec_after_done", 32'(out_valid), 32'd0);
    drain();

    // Reset mid-EXEC abandons the request.
    send(2'b10, 3'b000, 1'b0, 32'd3, 32'd4, w);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_srca", SrcA, 32'd0);
    chk("midrst_srcb", SrcB, 32'd0);
    chk("midrst_operation", 32'(Operation), 32'd0);
    chk("midrst_result", Result, 32'd0);
    chk("midrst_illegal", 32'(Illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (($urandom % 4) == 0) ? a : $urandom;
      send(2'($urandom), 3'($urandom), 1'($urandom), a, b, w);
      idle(int'($urandom_range(0, 2)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
